// File: rtl/cadence_period.sv
// cadence_period
//   Measures the pedal revolution period in prescaled ticks and reports a
//   4-deep moving average of the most recent periods.
//
//   Parameters
//     FAST_SIM      1: 16 clocks per tick, 0: 4096 clocks per tick
//   Ports
//     clk           system clock (50 MHz), sole clock
//     rst           synchronous, active-high reset
//     cadence_rise  one-cycle pulse per pedal revolution (already synchronous)
//     cadence_per   averaged revolution period in ticks, registered
//     per_vld       one-cycle pulse: cadence_per was just updated
//     not_pedaling  high while no valid revolution period exists
module cadence_period #(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cadence_rise,
    output logic [15:0] cadence_per,
    output logic        per_vld,
    output logic        not_pedaling
);

    localparam int PRE_W = (FAST_SIM != 0) ? 4 : 12;

    typedef enum logic [1:0] {
        STOPPED,
        ARMED,
        RUNNING
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [15:0]        tick_cnt;
    logic [15:0]        hist [4];
    logic [17:0]        sum;
    logic [17:0]        sum_roll;
    logic               timeout;

    assign tick = &pre_cnt;

    // Rolling sum with the oldest history entry swapped for the new period.
    // Four 16-bit values fit in 18 bits, so this never overflows.
    assign sum_roll = sum - {2'b00, hist[3]} + {2'b00, tick_cnt};

    // Prescaler and period counter; a revolution restarts both so the next
    // capture measures exactly the distance between rises.
    always_ff @(posedge clk) begin
        if (rst || cadence_rise) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
            if (tick && tick_cnt != 16'hFFFF) begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STOPPED;
        end else begin
            state <= state_nxt;
        end
    end

    // A rise on the saturated cycle is still a valid (maximal) period, so the
    // rise takes precedence over the timeout.
    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            STOPPED: begin
                if (cadence_rise) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (cadence_rise) begin
                    state_nxt = RUNNING;
                end else if (tick_cnt == 16'hFFFF) begin
                    state_nxt = STOPPED;
                    timeout   = 1'b1;
                end
            end
            RUNNING: begin
                if (!cadence_rise && tick_cnt == 16'hFFFF) begin
                    state_nxt = STOPPED;
                    timeout   = 1'b1;
                end
            end
            default: state_nxt = STOPPED;
        endcase
    end

    // History, sum and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hist[i] <= '0;
            end
            sum          <= '0;
            cadence_per  <= 16'hFFFF;
            per_vld      <= 1'b0;
            not_pedaling <= 1'b1;
        end else begin
            per_vld <= 1'b0;
            if (cadence_rise && state == ARMED) begin
                // First measured period primes the whole average window.
                for (int i = 0; i < 4; i++) begin
                    hist[i] <= tick_cnt;
                end
                sum          <= {tick_cnt, 2'b00};
                cadence_per  <= tick_cnt;
                per_vld      <= 1'b1;
                not_pedaling <= 1'b0;
            end else if (cadence_rise && state == RUNNING) begin
                for (int i = 3; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0]     <= tick_cnt;
                sum         <= sum_roll;
                cadence_per <= sum_roll[17:2];
                per_vld     <= 1'b1;
            end else if (timeout) begin
                for (int i = 0; i < 4; i++) begin
                    hist[i] <= '0;
                end
                sum          <= '0;
                cadence_per  <= 16'hFFFF;
                not_pedaling <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cadence_period.md
CADENCE_PERIOD -- requirements
Module: cadence_period

Interface
REQ-001 Parameter: FAST_SIM, default 1, selects prescale 16 (FAST_SIM=1) or 4096 (FAST_SIM=0) clocks per tick.
REQ-002 clk  input  1  50MHz system clock; sole clock of the block.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cadence_rise  input  1  single-cycle pulse, one per pedal revolution, from the upstream cadence filter (already synchronous, debounced).
REQ-005 cadence_per  output  16  averaged revolution period in ticks, registered.
REQ-006 per_vld  output  1  single-cycle pulse, cadence_per just updated.
REQ-007 not_pedaling  output  1  high while no valid revolution period exists.

Function
REQ-008 Prescaler pre_cnt (4 bits when FAST_SIM=1, 12 bits otherwise) SHALL increment every clk and wrap; tick SHALL be asserted when pre_cnt is all ones.
REQ-009 Period counter tick_cnt (16 bits) SHALL increment on tick and saturate at 16'hFFFF, with no wrap.
REQ-010 On any cadence_rise, pre_cnt and tick_cnt SHALL both load 0 at that clock edge, with priority over increment.
REQ-011 For rises N clocks apart, the captured period SHALL be floor((N-1)/PRESCALE), saturated at 16'hFFFF.
REQ-012 FSM states: STOPPED (reset state), ARMED, RUNNING.
REQ-013 STOPPED: cadence_rise -> ARMED; no output update.
REQ-014 ARMED: cadence_rise -> RUNNING; the captured period P primes all four history entries and the sum (sum = 4*P); cadence_per <= P; per_vld pulses; not_pedaling <= 0.
REQ-015 RUNNING: cadence_rise -> remain; push P into the 4-entry history and drop the oldest entry; sum <= sum - oldest + P; cadence_per <= (sum - oldest + P) >> 2; per_vld pulses.
REQ-016 Sum register SHALL be 18 bits wide so that it never overflows; the right shift truncates.
REQ-017 Timeout: in ARMED or RUNNING, tick_cnt == 16'hFFFF with no cadence_rise in that cycle -> STOPPED; history and sum <= 0; cadence_per <= 16'hFFFF; not_pedaling <= 1; per_vld stays 0.
REQ-018 cadence_rise in the same cycle as the timeout condition: the rise wins; the period is captured as 16'hFFFF under the normal ARMED/RUNNING rules.
REQ-019 per_vld and the cadence_per update SHALL occur on the clock edge that samples cadence_rise (visible one cycle after the rise), and only from ARMED or RUNNING.
REQ-020 Back-to-back rises on consecutive cycles: each rise SHALL be processed; the period captured is 0.
REQ-021 cadence_per and not_pedaling SHALL hold their values between updates.

Reset
REQ-022 With rst high at a clk edge: state <= STOPPED; pre_cnt, tick_cnt, history, sum <= 0; cadence_per <= 16'hFFFF; per_vld <= 0; not_pedaling <= 1.
REQ-023 rst SHALL override cadence_rise and any in-flight measurement; no per_vld pulse follows a reset until two further rises occur.

Verification (FAST_SIM=1)
REQ-024 Reset, then a single rise -> not_pedaling stays 1, per_vld never pulses, cadence_per = 16'hFFFF.
REQ-025 Rises every 1601 clocks, x3 -> first per_vld one cycle after the 2nd rise with cadence_per = 0x0064; the 3rd rise again gives 0x0064; not_pedaling = 0.
REQ-026 Steady 1601-clock spacing, then spacing 3201 clocks (P = 200) -> cadence_per = 0x007D (125) after the first longer period.
REQ-027 Pedaling, then no rise for 16*65535+ clocks -> not_pedaling = 1, cadence_per = 16'hFFFF, FSM STOPPED; the next two rises re-prime the average.
REQ-028 rst asserted mid-period in RUNNING, together with a cadence_rise -> all outputs equal their reset values the next cycle; no per_vld.
REQ-029 Rise on the exact timeout cycle (tick_cnt = 16'hFFFF) -> per_vld pulses and not_pedaling stays 0.
